load_down_counter_ctrl: RTL and testbench
=========================================

LOAD_DOWN_COUNTER_CTRL -- requirements
Module: load_down_counter_ctrl

Interface
REQ-001 Parameter: N, default 4, counter width in bits, legal range 4..8.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_valid  input  1  requester offers a new count job.
REQ-005 start_ready  output  1  block can accept a job this cycle.
REQ-006 load_val  input  N  initial count, sampled on accept.
REQ-007 auto_reload  input  1  periodic-mode flag, sampled on accept.
REQ-008 pause  input  1  freezes counting while high.
REQ-009 abort  input  1  cancels the current job.
REQ-010 count  output  N  current counter value.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 tick  output  1  one-cycle pulse at expiry.

Function
REQ-013 States SHALL be IDLE, COUNT and DONE.
REQ-014 start_ready SHALL equal (state==IDLE); start_valid outside IDLE SHALL be ignored.
REQ-015 Accept = start_valid & start_ready; on accept: count<=load_val, reload_reg<=load_val, mode_reg<=auto_reload.
REQ-016 Accept with load_val!=0 -> COUNT; accept with load_val==0 -> DONE directly.
REQ-017 In COUNT with pause low: count==1 -> count<=0, state<=DONE; otherwise count<=count-1.
REQ-018 In COUNT with pause high: count and state SHALL hold.
REQ-019 Next-count SHALL come from the decrementor sub-module; the controller SHALL never decrement a zero value, so no wrap to all-ones occurs.
REQ-020 tick SHALL equal (state==DONE), decoded from registered state only, and SHALL last exactly one cycle per expiry.
REQ-021 In DONE with mode_reg=1 and reload_reg!=0: count<=reload_reg, state<=COUNT; otherwise state<=IDLE and count stays 0.
REQ-022 Latency: with load_val=L>=1 accepted at edge k, tick SHALL be high in the cycle after edge k+L, plus one cycle per paused cycle.
REQ-023 Periodic mode without pause SHALL give a tick every reload_reg+1 cycles.
REQ-024 abort in COUNT or DONE: state<=IDLE and count<=0 at the next edge, with no tick produced from COUNT.
REQ-025 abort SHALL take priority over pause and reload; abort in IDLE has no effect.
REQ-026 pause in DONE SHALL be ignored.
REQ-027 An accept and an abort in the same IDLE cycle: the accept wins.

Reset
REQ-028 rst high at a clock edge SHALL force state=IDLE, count=0, reload_reg=0, mode_reg=0, giving tick=0, busy=0 and start_ready=1 in the following cycle.
REQ-029 rst SHALL override all inputs, including in mid-count and DONE states.

Structure
REQ-030 State encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) SHALL live in the shared arithmetic package/header.
REQ-031 Exactly one sub-module, decrementor (parameter N), SHALL compute count-1.
REQ-032 All state SHALL be in a single clocked process; outputs SHALL be registered or decoded from registered state.

Verification
REQ-033 N=4, load_val=3, auto_reload=0, accept at edge 0 -> count 3,2,1,0; tick high only in cycle after edge 3; then IDLE with start_ready=1.
REQ-034 load_val=0 accepted -> tick high in the cycle immediately after accept, busy high for that one cycle, then IDLE.
REQ-035 load_val=2, auto_reload=1, run 12 cycles -> ticks spaced exactly 3 cycles apart, count sequence 2,1,0,2,1,0...
REQ-036 load_val=5, pause high for 2 cycles while count==3 -> count holds 3 for 2 cycles; tick delayed by exactly 2 cycles.
REQ-037 load_val=4, abort at count==2 -> next cycle IDLE, count=0, no tick; start_valid during COUNT ignored.
REQ-038 N=8, load_val=8'hFF, rst asserted at count==8'h80 -> next cycle count=0, busy=0, tick=0; a fresh job is then accepted normally.

Source files
------------

// File: rtl/load_down_counter_ctrl_pkg.sv
// Shared definitions for the loadable down-counter controller.
package load_down_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/load_down_counter_ctrl_decrementor.sv
// Combinational N-bit decrementor used for the counter next value.
module load_down_counter_ctrl_decrementor #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] value,
  output logic [N-1:0] value_dec
);

  assign value_dec = value - {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/load_down_counter_ctrl.sv
// Loadable down counter with one-shot/periodic modes, pause, abort and expiry tick.
module load_down_counter_ctrl
  import load_down_counter_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         tick
);

  localparam logic [N-1:0] CountOne = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [N-1:0] count_q;
  logic [N-1:0] reload_q;
  logic         mode_q;
  logic [N-1:0] count_dec;

  load_down_counter_ctrl_decrementor #(
    .N (N)
  ) u_decrementor (
    .value     (count_q),
    .value_dec (count_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Abort is meaningless here, so an accept always wins.
          if (start_valid) begin
            count_q  <= load_val;
            reload_q <= load_val;
            mode_q   <= auto_reload;
            state_q  <= (load_val != '0) ? StCount : StDone;
          end
        end
        StCount: begin
          if (abort) begin
            state_q <= StIdle;
            count_q <= '0;
          end else if (!pause) begin
            // count_q is never zero here, so the decrement cannot wrap.
            if (count_q == CountOne) begin
              count_q <= '0;
              state_q <= StDone;
            end else begin
              count_q <= count_dec;
            end
          end
        end
        StDone: begin
          if (abort) begin
            state_q <= StIdle;
            count_q <= '0;
          end else if (mode_q && (reload_q != '0)) begin
            count_q <= reload_q;
            state_q <= StCount;
          end else begin
            count_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          count_q <= '0;
        end
      endcase
    end
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign tick        = (state_q == StDone);
  assign count       = count_q;

endmodule

// File: tb/tb_load_down_counter_ctrl.sv
// Self-checking bench: directed scenarios plus randomized run against a behavioural model.
module tb_load_down_counter_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       rst = 1'b1, sv = 1'b0, ar = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [3:0] ld = '0;
  logic       sr4, busy4, tick4;
  logic [3:0] count4;

  // N=8 instance
  logic       rst8 = 1'b1, sv8 = 1'b0, ar8 = 1'b0, pause8 = 1'b0, abort8 = 1'b0;
  logic [7:0] ld8 = '0;
  logic       sr8, busy8, tick8;
  logic [7:0] count8;

  int n_checks = 0;
  int n_fail   = 0;

  load_down_counter_ctrl #(.N(4)) dut4 (
    .clk (clk), .rst (rst), .start_valid (sv), .start_ready (sr4), .load_val (ld),
    .auto_reload (ar), .pause (pause), .abort (abort), .count (count4), .busy (busy4),
    .tick (tick4)
  );

  load_down_counter_ctrl #(.N(8)) dut8 (
    .clk (clk), .rst (rst8), .start_valid (sv8), .start_ready (sr8), .load_val (ld8),
    .auto_reload (ar8), .pause (pause8), .abort (abort8), .count (count8), .busy (busy8),
    .tick (tick8)
  );

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sv = 1'b1; ld = 4'd5;
    step(); step();
    n_checks++;
    if ({count4, busy4, tick4, sr4} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset4: got count=%0d busy=%0b tick=%0b ready=%0b, expected 0 0 0 1",
               count4, busy4, tick4, sr4);
    end
    n_checks++;
    if ({count8, busy8, tick8, sr8} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset8: got count=%0d busy=%0b tick=%0b ready=%0b, expected 0 0 0 1",
               count8, busy8, tick8, sr8);
    end
    sv = 1'b0; ld = 4'd0; rst = 1'b0;
    step();
    // Reset mid-count.
    sv = 1'b1; ld = 4'd9; step(); sv = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if ({count4, busy4, tick4, sr4} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midcount: got count=%0d busy=%0b tick=%0b ready=%0b, expected 0 0 0 1",
               count4, busy4, tick4, sr4);
    end
  endtask

  task automatic test_single_shot();
    int exp_cnt[5]  = '{3, 2, 1, 0, 0};
    int exp_tick[5] = '{0, 0, 0, 1, 0};
    int exp_busy[5] = '{1, 1, 1, 1, 0};
    sv = 1'b1; ld = 4'd3; ar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      sv = 1'b0;
      n_checks++;
      if (int'(count4) != exp_cnt[i] || int'(tick4) != exp_tick[i] ||
          int'(busy4) != exp_busy[i] || sr4 !== !exp_busy[i][0]) begin
        n_fail++;
        $display("FAIL single_shot[%0d]: got count=%0d tick=%0b busy=%0b ready=%0b, expected %0d %0d %0d",
                 i, count4, tick4, busy4, sr4, exp_cnt[i], exp_tick[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_zero_load();
    sv = 1'b1; ld = 4'd0; ar = 1'b1;
    step(); sv = 1'b0; ar = 1'b0;
    n_checks++;
    if ({count4, busy4, tick4} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load_tick: got count=%0d busy=%0b tick=%0b, expected 0 1 1",
               count4, busy4, tick4);
    end
    step();
    n_checks++;
    if ({busy4, tick4, sr4} !== {1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_load_idle: got busy=%0b tick=%0b ready=%0b, expected 0 0 1",
               busy4, tick4, sr4);
    end
  endtask

  task automatic test_periodic();
    sv = 1'b1; ld = 4'd2; ar = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      sv = 1'b0; ar = 1'b0;
      n_checks++;
      if (int'(count4) != 2 - (i % 3) || tick4 !== (i % 3 == 2) || busy4 !== 1'b1) begin
        n_fail++;
        $display("FAIL periodic[%0d]: got count=%0d tick=%0b busy=%0b, expected %0d %0b 1",
                 i, count4, tick4, busy4, 2 - (i % 3), (i % 3 == 2));
      end
    end
    abort = 1'b1; step(); abort = 1'b0;
    n_checks++;
    if ({count4, busy4, tick4} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL periodic_abort: got count=%0d busy=%0b tick=%0b, expected 0 0 0",
               count4, busy4, tick4);
    end
  endtask

  task automatic test_pause();
    int exp_cnt[9]  = '{5, 4, 3, 3, 3, 2, 1, 0, 0};
    int exp_tick[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    sv = 1'b1; ld = 4'd5; ar = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      sv = 1'b0;
      n_checks++;
      if (int'(count4) != exp_cnt[i] || int'(tick4) != exp_tick[i]) begin
        n_fail++;
        $display("FAIL pause[%0d]: got count=%0d tick=%0b, expected %0d %0d",
                 i, count4, tick4, exp_cnt[i], exp_tick[i]);
      end
      // Pause across the two edges following count==3; also pause while expired.
      pause = (i == 2 || i == 3 || i == 7);
    end
    n_checks++;
    if ({busy4, sr4} !== 2'b01) begin
      n_fail++;
      $display("FAIL pause_done_ignored: got busy=%0b ready=%0b, expected 0 1", busy4, sr4);
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    sv = 1'b1; ld = 4'd4;
    step();                              // 4
    ld = 4'd7; step();                   // start during COUNT ignored: 3
    sv = 1'b0;
    n_checks++;
    if (count4 !== 4'd3) begin
      n_fail++;
      $display("FAIL start_ignored: got count=%0d, expected 3", count4);
    end
    step();                              // 2
    abort = 1'b1; pause = 1'b1; step(); abort = 1'b0; pause = 1'b0;
    n_checks++;
    if ({count4, busy4, tick4, sr4} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_count: got count=%0d busy=%0b tick=%0b ready=%0b, expected 0 0 0 1",
               count4, busy4, tick4, sr4);
    end
    step();
    n_checks++;
    if (tick4 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_tick: got tick=%0b, expected 0", tick4);
    end
    // Accept and abort together in IDLE: accept wins.
    sv = 1'b1; abort = 1'b1; ld = 4'd2; step(); sv = 1'b0; abort = 1'b0;
    n_checks++;
    if ({count4, busy4} !== {4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL accept_over_abort: got count=%0d busy=%0b, expected 2 1", count4, busy4);
    end
    step(); step();
    // Abort in DONE.
    abort = 1'b1; step(); abort = 1'b0;
    n_checks++;
    if ({count4, busy4, tick4} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_done: got count=%0d busy=%0b tick=%0b, expected 0 0 0",
               count4, busy4, tick4);
    end
  endtask

  task automatic test_wide_reset();
    int guard = 0;
    rst8 = 1'b0; sv8 = 1'b1; ld8 = 8'hFF;
    step(); sv8 = 1'b0;
    while (count8 !== 8'h80 && guard < 400) begin
      step();
      guard++;
    end
    n_checks++;
    if (count8 !== 8'h80 || guard != 127) begin
      n_fail++;
      $display("FAIL wide_reach80: got count=%0h after %0d cycles, expected 80 after 127",
               count8, guard);
    end
    rst8 = 1'b1; sv8 = 1'b1; step(); rst8 = 1'b0; sv8 = 1'b0;
    n_checks++;
    if ({count8, busy8, tick8, sr8} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_reset: got count=%0h busy=%0b tick=%0b ready=%0b, expected 0 0 0 1",
               count8, busy8, tick8, sr8);
    end
    sv8 = 1'b1; ld8 = 8'd3; step(); sv8 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if ({count8, tick8, busy8} !== {8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_fresh_job: got count=%0d tick=%0b busy=%0b, expected 0 1 1",
               count8, tick8, busy8);
    end
  endtask

  // Behavioural model: job activity, remaining count, and whether the job just expired.
  task automatic test_random();
    int  m_cnt = 0, m_reload = 0;
    bit  m_active = 0, m_expired = 0, m_periodic = 0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      sv    = ($urandom_range(0, 1) == 1);
      ld    = 4'($urandom_range(0, 15));
      ar    = ($urandom_range(0, 1) == 1);
      pause = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_expired = 0; m_cnt = 0; m_reload = 0; m_periodic = 0;
      end else if (!m_active) begin
        if (sv) begin
          m_active = 1; m_reload = int'(ld); m_periodic = ar; m_cnt = int'(ld);
          m_expired = (ld == 0);
        end
      end else if (abort) begin
        m_active = 0; m_expired = 0; m_cnt = 0;
      end else if (m_expired) begin
        m_expired = 0;
        if (m_periodic && m_reload != 0) m_cnt = m_reload;
        else begin m_active = 0; m_cnt = 0; end
      end else if (!pause) begin
        m_cnt = m_cnt - 1;
        m_expired = (m_cnt == 0);
      end
      #1;
      n_checks++;
      if (int'(count4) != m_cnt || busy4 !== m_active || tick4 !== m_expired ||
          sr4 !== !m_active) begin
        n_fail++;
        $display("FAIL random[%0d]: got count=%0d busy=%0b tick=%0b ready=%0b, expected %0d %0b %0b %0b",
                 c, count4, busy4, tick4, sr4, m_cnt, m_active, m_expired, !m_active);
      end
    end
    sv = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_shot();
    test_zero_load();
    test_periodic();
    test_pause();
    test_abort();
    test_wide_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
